// File: rtl/fft_drv_pkg.sv
// Shared types and sizing helpers for the FFT frame driver.
package fft_drv_pkg;

  // Driver sequencing: fill a frame, kick the host, wait for it, drain results.
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } drv_state_t;

  localparam int FFT_SIZE_DEF = 8;
  localparam int TIMEOUT_DEF  = 255;

  // Bits needed to address one sample of a frame (at least one bit).
  function automatic int idx_width(input int fft_size);
    return (fft_size > 1) ? $clog2(fft_size) : 1;
  endfunction

  // Bits needed for a watchdog that counts up to and including the timeout.
  function automatic int wdog_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  localparam int IDX_W  = idx_width(FFT_SIZE_DEF);
  localparam int WDOG_W = wdog_width(TIMEOUT_DEF);

endpackage

// File: rtl/fft_frame_driver_if.sv
// Bundle of the sample stream, host bus and result stream around the driver.
// master: the driver's view; slave: the surrounding source/host/sink view.
interface fft_frame_driver_if
  import fft_drv_pkg::*;
#(
  parameter int FFT_SIZE   = 8,
  parameter int DATA_WIDTH = 16
);
  localparam int IDX_BITS = idx_width(FFT_SIZE);
  localparam int FLAT_W   = FFT_SIZE * DATA_WIDTH;

  // Sample input stream
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_real;
  logic [DATA_WIDTH-1:0] in_imag;
  logic [1:0]            in_mode;

  // FFT host side
  logic [FLAT_W-1:0]     fft_data_real_flat;
  logic [FLAT_W-1:0]     fft_data_imag_flat;
  logic [1:0]            fft_mode;
  logic                  fft_start;
  logic [FLAT_W-1:0]     fft_result_real_flat;
  logic [FLAT_W-1:0]     fft_result_imag_flat;
  logic                  fft_done;

  // Result output stream
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_real;
  logic [DATA_WIDTH-1:0] out_imag;
  logic [IDX_BITS-1:0]   out_index;
  logic                  out_last;

  // Status
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  in_valid, in_real, in_imag, in_mode,
    output in_ready,
    output fft_data_real_flat, fft_data_imag_flat, fft_mode, fft_start,
    input  fft_result_real_flat, fft_result_imag_flat, fft_done,
    output out_valid, out_real, out_imag, out_index, out_last,
    input  out_ready,
    output busy, timeout_err
  );

  modport slave (
    output in_valid, in_real, in_imag, in_mode,
    input  in_ready,
    input  fft_data_real_flat, fft_data_imag_flat, fft_mode, fft_start,
    output fft_result_real_flat, fft_result_imag_flat, fft_done,
    input  out_valid, out_real, out_imag, out_index, out_last,
    output out_ready,
    input  busy, timeout_err
  );

endinterface

// File: rtl/fft_result_serializer.sv
// Captures the host's flattened results on completion and replays them as an
// indexed valid/ready stream. The capture decouples the output from any later
// host activity on the result buses.
module fft_result_serializer
  import fft_drv_pkg::*;
#(
  parameter int FFT_SIZE   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_BITS   = idx_width(FFT_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           capture,
  input  logic                           active,
  input  logic [FFT_SIZE*DATA_WIDTH-1:0] res_real,
  input  logic [FFT_SIZE*DATA_WIDTH-1:0] res_imag,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_real,
  output logic [DATA_WIDTH-1:0]          out_imag,
  output logic [IDX_BITS-1:0]            out_index,
  output logic                           out_last,
  output logic                           stream_done
);
  localparam int FLAT_W = FFT_SIZE * DATA_WIDTH;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FFT_SIZE - 1);

  logic [FLAT_W-1:0]   cap_real;
  logic [FLAT_W-1:0]   cap_imag;
  logic [IDX_BITS-1:0] idx;
  logic                at_last;
  logic                out_hs;

  assign at_last     = (idx == LAST_IDX);
  assign out_hs      = active && out_ready;

  // Outputs are pure functions of the captured frame and the read index, so
  // they hold still for as long as the sink stalls.
  assign out_valid   = active;
  assign out_index   = idx;
  assign out_last    = active && at_last;
  assign out_real    = cap_real[idx*DATA_WIDTH +: DATA_WIDTH];
  assign out_imag    = cap_imag[idx*DATA_WIDTH +: DATA_WIDTH];
  assign stream_done = out_hs && at_last;

  // Snapshot results on done; advance the read index on each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_real <= '0;
      cap_imag <= '0;
      idx      <= '0;
    end else if (capture) begin
      cap_real <= res_real;
      cap_imag <= res_imag;
      idx      <= '0;
    end else if (out_hs) begin
      idx <= at_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_driver.sv
// Initiator-side driver for the FFT host: gathers a streamed complex frame
// into the host's flattened buses, pulses start, waits for done under a
// watchdog, then streams the captured results back out.
module fft_frame_driver
  import fft_drv_pkg::*;
#(
  parameter int FFT_SIZE   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input logic                clk,
  input logic                rst,
  fft_frame_driver_if.master bus
);
  localparam int IDX_BITS  = idx_width(FFT_SIZE);
  localparam int WDOG_BITS = wdog_width(TIMEOUT);
  localparam int FLAT_W    = FFT_SIZE * DATA_WIDTH;

  localparam logic [IDX_BITS-1:0]  LAST_LOAD = IDX_BITS'(FFT_SIZE - 1);
  // The abort decision is made in the cycle whose increment would bring the
  // counter to TIMEOUT, so the error and the return to LOAD show the cycle
  // after the TIMEOUT-th WAIT cycle.
  localparam logic [WDOG_BITS-1:0] WDOG_LAST = WDOG_BITS'(TIMEOUT - 1);

  drv_state_t           state;
  drv_state_t           state_next;

  logic [IDX_BITS-1:0]  load_idx;
  logic [FLAT_W-1:0]    data_real;
  logic [FLAT_W-1:0]    data_imag;
  logic [1:0]           mode;
  logic [WDOG_BITS-1:0] wdog;
  logic                 tmo_err;

  logic                 in_ready;
  logic                 start_pulse;
  logic                 busy;
  logic                 in_hs;
  logic                 last_load;
  logic                 done_take;
  logic                 wdog_expire;
  logic                 unload_active;
  logic                 unload_done;

  assign in_hs         = in_ready && bus.in_valid;
  assign last_load     = in_hs && (load_idx == LAST_LOAD);
  // Done is honoured only while waiting; stray pulses elsewhere are ignored.
  assign done_take     = (state == WAIT) && bus.fft_done;
  // A done in the expiry cycle wins over the watchdog.
  assign wdog_expire   = (state == WAIT) && !bus.fft_done && (wdog == WDOG_LAST);
  assign unload_active = (state == UNLOAD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection and state-decoded handshake/status outputs.
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    start_pulse = 1'b0;
    busy        = 1'b1;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (last_load) begin
          state_next = START;
        end
      end
      START: begin
        start_pulse = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        if (done_take) begin
          state_next = UNLOAD;
        end else if (wdog_expire) begin
          state_next = LOAD;
        end
      end
      UNLOAD: begin
        if (unload_done) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Frame packing: the flats only change on input handshakes, so they stay
  // put from START until the first write of the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_real <= '0;
      data_imag <= '0;
      mode      <= '0;
      load_idx  <= '0;
    end else begin
      if (in_hs) begin
        data_real[load_idx*DATA_WIDTH +: DATA_WIDTH] <= bus.in_real;
        data_imag[load_idx*DATA_WIDTH +: DATA_WIDTH] <= bus.in_imag;
        if (load_idx == '0) begin
          mode <= bus.in_mode;
        end
        load_idx <= last_load ? '0 : load_idx + 1'b1;
      end
      // An aborted frame restarts from sample 0.
      if (wdog_expire) begin
        load_idx <= '0;
      end
    end
  end

  // Watchdog: cleared as start is issued, counts every WAIT cycle, and the
  // sticky error survives everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog    <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state == START) begin
        wdog <= '0;
      end else if (state == WAIT) begin
        wdog <= wdog + 1'b1;
      end
      if (wdog_expire) begin
        tmo_err <= 1'b1;
      end
    end
  end

  fft_result_serializer #(
    .FFT_SIZE   (FFT_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_BITS   (IDX_BITS)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .capture     (done_take),
    .active      (unload_active),
    .res_real    (bus.fft_result_real_flat),
    .res_imag    (bus.fft_result_imag_flat),
    .out_ready   (bus.out_ready),
    .out_valid   (bus.out_valid),
    .out_real    (bus.out_real),
    .out_imag    (bus.out_imag),
    .out_index   (bus.out_index),
    .out_last    (bus.out_last),
    .stream_done (unload_done)
  );

  assign bus.in_ready           = in_ready;
  assign bus.fft_start          = start_pulse;
  assign bus.busy               = busy;
  assign bus.fft_data_real_flat = data_real;
  assign bus.fft_data_imag_flat = data_imag;
  assign bus.fft_mode           = mode;
  assign bus.timeout_err        = tmo_err;

endmodule

// File: tb/tb_fft_frame_driver.sv
// Bench for fft_frame_driver: a frame table drives loads, a host model answers
// start with done and pushes the expected result stream into a scoreboard that
// a negedge monitor drains; hand-written sequences cover watchdog and reset.
module tb_fft_frame_driver;
  localparam int N   = 8;
  localparam int W   = 16;
  localparam int TMO = 16;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] in_r;
    logic [15:0] in_i;
    logic [15:0] res_r;
    logic [15:0] res_i;
    int          lat;      // cycles from start to done; -1 = host never answers
    logic [3:0]  rdy;      // out_ready pattern indexed by cycle mod 4
    bit          gaps;     // idle cycle before every odd sample
    bit          stray;    // stray done during LOAD and START
    bit          exp_tmo;  // timeout_err expected after this frame
    logic [15:0] exp_lo;   // expected real sample 0 on the flat bus
    logic [15:0] exp_hi;   // expected real sample 7 on the flat bus
  } frame_vec_t;

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    logic [2:0]  idx;
    logic        last;
  } out_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_driver_if #(.FFT_SIZE(N), .DATA_WIDTH(W)) bus ();

  fft_frame_driver #(.FFT_SIZE(N), .DATA_WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_start = 0;
  int n_out = 0;
  int first_valid_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  int host_lat = -1;
  logic [15:0] host_r = '0;
  logic [15:0] host_i = '0;
  logic host_done = 1'b0;
  logic stray_done = 1'b0;
  out_exp_t sb[$];
  frame_vec_t tbl[6];

  assign bus.fft_done = host_done | stray_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host model: answers each start with done after host_lat cycles, then
  // scribbles over its result buses to prove the driver captured them.
  initial begin
    logic [127:0] tr, ti;
    out_exp_t e;
    bus.fft_result_real_flat = '0;
    bus.fft_result_imag_flat = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.fft_start && host_lat >= 0) begin
        repeat (host_lat) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
          tr[k*W +: W] = 16'(host_r + 16'(k));
          ti[k*W +: W] = 16'(host_i + 16'(k));
          e.r = 16'(host_r + 16'(k));
          e.i = 16'(host_i + 16'(k));
          e.idx = 3'(k);
          e.last = (k == N - 1);
          sb.push_back(e);
        end
        bus.fft_result_real_flat = tr;
        bus.fft_result_imag_flat = ti;
        host_done = 1'b1;
        done_cyc = cyc;
        tick();
        host_done = 1'b0;
        bus.fft_result_real_flat = {N{16'hDEAD}};
        bus.fft_result_imag_flat = {N{16'hBEEF}};
      end
    end
  end

  // Output monitor: scoreboard compare on each handshake, stall stability.
  initial begin
    out_exp_t e;
    logic vld_prev;
    logic held;
    logic [15:0] held_r, held_i;
    logic [2:0] held_idx;
    vld_prev = 1'b0;
    held = 1'b0;
    held_r = '0;
    held_i = '0;
    held_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        vld_prev = 1'b0;
        sb.delete();
      end else begin
        if (bus.fft_start) n_start++;
        if (bus.out_valid && !vld_prev) first_valid_cyc = cyc;
        if (held) begin
          check("stall_valid", bus.out_valid, 1'b1);
          check("stall_real", bus.out_real, held_r);
          check("stall_imag", bus.out_imag, held_i);
          check("stall_index", bus.out_index, held_idx);
        end
        held = 1'b0;
        if (bus.out_valid) begin
          if (bus.out_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_out", 1'b1, 1'b0);
            end else begin
              e = sb.pop_front();
              check("out_real", bus.out_real, e.r);
              check("out_imag", bus.out_imag, e.i);
              check("out_index", bus.out_index, e.idx);
              check("out_last", bus.out_last, e.last);
            end
            n_out++;
            last_hs_cyc = cyc;
          end else begin
            held = 1'b1;
            held_r = bus.out_real;
            held_i = bus.out_imag;
            held_idx = bus.out_index;
          end
        end
        vld_prev = bus.out_valid;
      end
    end
  end

  // Streams one frame in, then checks the start pulse and the packed buses.
  task automatic load_frame(input frame_vec_t v, output logic [127:0] er);
    logic [127:0] ei;
    int waited;
    for (int k = 0; k < N; k++) begin
      if (v.gaps && (k % 2 == 1)) begin
        bus.in_valid = 1'b0;
        bus.in_real = 16'hFFFF;
        tick();
      end
      if (v.stray && k == 3) begin
        bus.in_valid = 1'b0;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        check("stray_load_ready", bus.in_ready, 1'b1);
        check("stray_load_busy", bus.busy, 1'b0);
      end
      bus.in_valid = 1'b1;
      bus.in_real = 16'(v.in_r + 16'(k));
      bus.in_imag = 16'(v.in_i + 16'(k));
      bus.in_mode = (k == 0) ? v.mode : 2'(~v.mode);
      waited = 0;
      while (!bus.in_ready && waited < 20) begin
        tick();
        waited++;
      end
      if (waited >= 20) check("load_ready_bound", 1'b0, 1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_real = 16'h5555;
    bus.in_imag = 16'hAAAA;
    bus.in_mode = 2'(~v.mode);
    check("start_pulse", bus.fft_start, 1'b1);
    check("start_busy", bus.busy, 1'b1);
    check("start_in_ready", bus.in_ready, 1'b0);
    if (v.stray) stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check("start_single", bus.fft_start, 1'b0);
    for (int k = 0; k < N; k++) begin
      er[k*W +: W] = 16'(v.in_r + 16'(k));
      ei[k*W +: W] = 16'(v.in_i + 16'(k));
    end
    check("flat_real", bus.fft_data_real_flat, er);
    check("flat_imag", bus.fft_data_imag_flat, ei);
    check("flat_lo", bus.fft_data_real_flat[15:0], v.exp_lo);
    check("flat_hi", bus.fft_data_real_flat[127:112], v.exp_hi);
    check("fft_mode", bus.fft_mode, v.mode);
  endtask

  task automatic run_frame(input frame_vec_t v);
    logic [127:0] er;
    int s0, o0, waited;
    host_r = v.res_r;
    host_i = v.res_i;
    host_lat = v.lat;
    s0 = n_start;
    o0 = n_out;
    load_frame(v, er);
    if (v.lat < 0) begin
      // Now in the first WAIT cycle; abort shows after the 16th.
      bus.out_ready = 1'b1;
      repeat (TMO - 1) tick();
      check("wd_pre_ready", bus.in_ready, 1'b0);
      check("wd_pre_err", bus.timeout_err, 1'b0);
      tick();
      check("wd_err", bus.timeout_err, 1'b1);
      check("wd_ready", bus.in_ready, 1'b1);
      check("wd_busy", bus.busy, 1'b0);
      check("wd_no_valid", bus.out_valid, 1'b0);
      repeat (3) tick();
      check("wd_no_out", n_out - o0, 0);
    end else begin
      waited = 0;
      while (!bus.in_ready && waited < 300) begin
        bus.out_ready = v.rdy[cyc[1:0]];
        tick();
        waited++;
      end
      check("unload_bound", (waited < 300), 1'b1);
      check("ready_after_last", cyc, last_hs_cyc + 1);
      check("out_count", n_out - o0, N);
      check("sb_empty", sb.size(), 0);
      check("valid_after_done", first_valid_cyc, done_cyc + 1);
      if (v.rdy == 4'hF) check("full_rate", last_hs_cyc - first_valid_cyc, N - 1);
    end
    check("start_count", n_start - s0, 1);
    check("flat_stable", bus.fft_data_real_flat, er);
    check("tmo_sticky", bus.timeout_err, v.exp_tmo);
    bus.out_ready = 1'b0;
    tick();
  endtask

  initial begin
    frame_vec_t v;
    int waited, s0, o0;
    logic [127:0] er;
    bus.in_valid = 1'b0;
    bus.in_real = '0;
    bus.in_imag = '0;
    bus.in_mode = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{2'd2, 16'h0100, 16'h0200, 16'hA000, 16'hB000, 10, 4'hF,    1'b0, 1'b0, 1'b0, 16'h0100, 16'h0107};
    tbl[1] = '{2'd1, 16'h7FF8, 16'h8000, 16'h8000, 16'h7FFF, 5,  4'b1001, 1'b1, 1'b0, 1'b0, 16'h7FF8, 16'h7FFF};
    tbl[2] = '{2'd3, 16'h0000, 16'hFFF8, 16'h1230, 16'h4560, 1,  4'b0110, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0007};
    tbl[3] = '{2'd0, 16'h0F00, 16'h0E00, 16'hC000, 16'hD000, 16, 4'hF,    1'b0, 1'b0, 1'b0, 16'h0F00, 16'h0F07};
    tbl[4] = '{2'd2, 16'h3300, 16'h4400, 16'h0000, 16'h0000, -1, 4'hF,    1'b0, 1'b0, 1'b1, 16'h3300, 16'h3307};
    tbl[5] = '{2'd1, 16'h5500, 16'h6600, 16'h9000, 16'h9100, 3,  4'b1010, 1'b1, 1'b0, 1'b1, 16'h5500, 16'h5507};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_start", bus.fft_start, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_tmo", bus.timeout_err, 1'b0);
    check("rst_flat_real", bus.fft_data_real_flat, 128'h0);
    check("rst_mode", bus.fft_mode, 2'd0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Reset in the middle of UNLOAD, with sample 3 on the output.
    v = '{2'd1, 16'h1234, 16'h2345, 16'h4000, 16'h5000, 4, 4'hF, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h123B};
    host_r = v.res_r;
    host_i = v.res_i;
    host_lat = v.lat;
    o0 = n_out;
    load_frame(v, er);
    bus.out_ready = 1'b1;
    waited = 0;
    while (!(bus.out_valid && bus.out_index == 3'd3) && waited < 100) begin
      tick();
      waited++;
    end
    check("mid_reach_idx3", (waited < 100), 1'b1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_outs_before", n_out - o0, 3);
    check("mid_out_valid", bus.out_valid, 1'b0);
    check("mid_out_last", bus.out_last, 1'b0);
    check("mid_out_index", bus.out_index, 3'd0);
    check("mid_out_real", bus.out_real, 16'h0);
    check("mid_out_imag", bus.out_imag, 16'h0);
    check("mid_flat_real", bus.fft_data_real_flat, 128'h0);
    check("mid_flat_imag", bus.fft_data_imag_flat, 128'h0);
    check("mid_mode", bus.fft_mode, 2'd0);
    check("mid_tmo_cleared", bus.timeout_err, 1'b0);
    check("mid_in_ready", bus.in_ready, 1'b1);
    check("mid_busy", bus.busy, 1'b0);
    s0 = n_start;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("mid_no_start", n_start - s0, 0);
    check("mid_no_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    run_frame('{2'd3, 16'h0A00, 16'h0B00, 16'h6000, 16'h7000, 6, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0A00, 16'h0A07});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish within 50000 cycles");
    $fatal(1, "simulation time limit");
  end

endmodule
